decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
Parametrised, pipelined successor to the combinational RV32I decoder. It buffers fetched instructions in a FIFO of depth FIFO_DEPTH and decodes the FIFO head into a registered output stage. Both the fetch side and the execute side use valid/ready handshakes. It adds flush, illegal-instruction flagging and back-pressure, and sits between fetch and execute/ALU.

Parameters:
XLEN, 32, data/immediate width (32 only in this generation; imm sign-extends to XLEN)
PC_WIDTH, 32, width of carried PC
FIFO_DEPTH, 4, instruction buffer entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  discard all buffered and staged instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  buffer can accept
in_code  in  32  instruction word
in_pc  in  PC_WIDTH  instruction address
out_valid  out  1  decoded instruction valid
out_ready  in  1  execute accepts
out_pc  out  PC_WIDTH  PC of decoded instruction
out_opcode  out  7  code[6:0]
out_func3  out  3  code[14:12]
out_func7  out  7  code[31:25]
out_rs1_num  out  5  source 1 (0 for U/J)
out_rs2_num  out  5  source 2 (0 for I/U/J)
out_rd_num  out  5  destination (0 for S/B)
out_imm  out  XLEN  decoded immediate
out_type  out  3  NONE=0,R=1,I=2,S=3,B=4,U=5,J=6
out_wb_reg  out  1  writes rd (I/R/U/J and not illegal)
out_illegal  out  1  unrecognised opcode
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_count=0, out_valid=0, all out_* data outputs=0. in_ready=1 from the first cycle after deassertion.
- FIFO push: in_valid && in_ready at an edge. in_ready = (fifo_count < FIFO_DEPTH). It is registered-state based and does not depend on in_valid or out_ready.
- Output stage load: at an edge, if FIFO non-empty and (!out_valid || out_ready), pop the head, load the decoded fields, and set out_valid=1. If instead out_valid && out_ready and the FIFO is empty, clear out_valid to 0.
- Latency: instruction accepted at edge T appears with out_valid=1 after edge T+1 when the FIFO was empty and the stage was free. No combinational input-to-output bypass.
- Simultaneous push and pop: count unchanged. When full, a pop at an edge does not enable a push at that same edge, because in_ready is already 0.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by count.
- Output fields stay stable while out_valid && !out_ready.
- Flush: at the edge where flush=1, FIFO empties, count=0 and out_valid=0. Any push or load at that edge is discarded; flush has priority.
- Type decode (opcode):
  - I: 0000011, 0010011, 1100111, 1110011, 0001111
  - U: 0110111, 0010111
  - R: 0110011
  - S: 0100011
  - B: 1100011
  - J: 1101111
  - otherwise NONE, with out_illegal=1.
- Immediate by type (standard RV32I encodings):
  - I: sext(code[31:20])
  - S: sext({code[31:25], code[11:7]})
  - B: sext({code[31], code[7], code[30:25], code[11:8], 0})
  - U: {code[31:12], 12'b0}
  - J: sext({code[31], code[19:12], code[20], code[30:21], 0})
  - NONE: 0
- Illegal instructions still flow through the handshake, with out_wb_reg=0 and register numbers zeroed.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, type=I, rd=1, rs1=0, rs2=0, imm=5, wb_reg=1, illegal=0.
- Hold out_ready=0 and push 5 instructions -> 1 in output stage plus 4 in FIFO, fifo_count=4, in_ready=0. The 6th push is refused. Release out_ready -> instructions retire in order, one per cycle, with PCs intact.
- Push 0xFE000EE3 (beq x0,x0,-4) -> type=B, imm=0xFFFFFFFC, rd=0, wb_reg=0. Push 0x800000EF (jal) -> imm=0xFFF00000.
- Push 0xFFFFFFFF -> out_illegal=1, type=0, imm=0, wb_reg=0, rd/rs1/rs2=0.
- Hold out_ready=0 with a full FIFO, then assert flush together with in_valid -> next cycle fifo_count=0, out_valid=0, and the pushed word is dropped.
- Assert rst_n=0 mid-stream, asynchronously and between edges -> out_valid and fifo_count drop immediately; first push after release decodes correctly.

Source files
------------

// File: rtl/decode_pipe_if.sv
// Valid/ready bus linking fetch, the decode pipe and execute.
// The master modport is the side that feeds fetch words and accepts decoded results.
interface decode_pipe_if #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_code;
  logic [PC_WIDTH-1:0] in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [2:0]          out_func3;
  logic [6:0]          out_func7;
  logic [4:0]          out_rs1_num;
  logic [4:0]          out_rs2_num;
  logic [4:0]          out_rd_num;
  logic [XLEN-1:0]     out_imm;
  logic [2:0]          out_type;
  logic                out_wb_reg;
  logic                out_illegal;

  modport master (
    output in_valid, in_code, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1_num, out_rs2_num, out_rd_num, out_imm, out_type,
           out_wb_reg, out_illegal
  );

  modport slave (
    input  in_valid, in_code, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
           out_rs1_num, out_rs2_num, out_rd_num, out_imm, out_type,
           out_wb_reg, out_illegal
  );
endinterface

// File: rtl/decode_pipe.sv
// Pipelined RV32I decoder: a FIFO of raw fetch words feeding one registered decode stage.
// Decoding happens on the FIFO head so the output stage only ever loads finished fields.
module decode_pipe #(
  parameter int XLEN       = 32,
  parameter int PC_WIDTH   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  decode_pipe_if.slave                  bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    TYPE_NONE = 3'd0,
    TYPE_R    = 3'd1,
    TYPE_I    = 3'd2,
    TYPE_S    = 3'd3,
    TYPE_B    = 3'd4,
    TYPE_U    = 3'd5,
    TYPE_J    = 3'd6
  } instr_type_e;

  logic [31:0]         codeMem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] pcMem_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop;
  logic [31:0]         head;
  logic [31:0]         imm32;

  instr_type_e         type_d, type_q;
  logic [4:0]          rs1_d, rs2_d, rd_d;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]     imm_d, imm_q;
  logic                wb_d, wb_q;
  logic                illegal_d, illegal_q;
  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [6:0]          opcode_q;
  logic [2:0]          func3_q;
  logic [6:0]          func7_q;

  // Full and empty are told apart by the count, so pointers simply wrap.
  assign bus.in_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count_q != '0) && (!valid_q || bus.out_ready);
  assign count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
  assign fifo_count   = count_q;
  assign head         = codeMem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      codeMem_q[wrPtr_q] <= bus.in_code;
      pcMem_q[wrPtr_q]   <= bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + PTR_W'(push);
      rdPtr_q <= rdPtr_q + PTR_W'(pop);
      count_q <= count_d;
    end
  end

  always_comb begin
    type_d    = TYPE_NONE;
    imm32     = '0;
    rs1_d     = '0;
    rs2_d     = '0;
    rd_d      = '0;
    wb_d      = 1'b0;
    illegal_d = 1'b0;
    case (head[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0001111:               type_d = TYPE_I;
      7'b0110111, 7'b0010111:               type_d = TYPE_U;
      7'b0110011:                           type_d = TYPE_R;
      7'b0100011:                           type_d = TYPE_S;
      7'b1100011:                           type_d = TYPE_B;
      7'b1101111:                           type_d = TYPE_J;
      default:                              type_d = TYPE_NONE;
    endcase
    // Register fields are only exposed for formats that actually encode them.
    case (type_d)
      TYPE_R: begin
        rs1_d = head[19:15];
        rs2_d = head[24:20];
        rd_d  = head[11:7];
        wb_d  = 1'b1;
      end
      TYPE_I: begin
        rs1_d = head[19:15];
        rd_d  = head[11:7];
        wb_d  = 1'b1;
        imm32 = {{20{head[31]}}, head[31:20]};
      end
      TYPE_S: begin
        rs1_d = head[19:15];
        rs2_d = head[24:20];
        imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
      end
      TYPE_B: begin
        rs1_d = head[19:15];
        rs2_d = head[24:20];
        imm32 = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      end
      TYPE_U: begin
        rd_d  = head[11:7];
        wb_d  = 1'b1;
        imm32 = {head[31:12], 12'b0};
      end
      TYPE_J: begin
        rd_d  = head[11:7];
        wb_d  = 1'b1;
        imm32 = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      end
      default: illegal_d = 1'b1;
    endcase
    imm_d = XLEN'($signed(imm32));
  end

  // Flush beats load; fields hold while the stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      func3_q   <= '0;
      func7_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      type_q    <= TYPE_NONE;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (pop) begin
      valid_q   <= 1'b1;
      pc_q      <= pcMem_q[rdPtr_q];
      opcode_q  <= head[6:0];
      func3_q   <= head[14:12];
      func7_q   <= head[31:25];
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      type_q    <= type_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_func3   = func3_q;
  assign bus.out_func7   = func7_q;
  assign bus.out_rs1_num = rs1_q;
  assign bus.out_rs2_num = rs2_q;
  assign bus.out_rd_num  = rd_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_type    = type_q;
  assign bus.out_wb_reg  = wb_q;
  assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus random traffic, all checked against
// a queue-based reference of the buffer and a field-level RV32I decode model.
module tb_decode_pipe;
  localparam int XLEN       = 32;
  localparam int PC_WIDTH   = 32;
  localparam int FIFO_DEPTH = 4;
  localparam logic [6:0] OPS [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F,
                                      7'h37, 7'h17, 7'h33, 7'h23, 7'h63};

  typedef struct packed {
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } ref_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  decode_pipe_if #(.XLEN(XLEN), .PC_WIDTH(PC_WIDTH)) bus ();

  decode_pipe #(.XLEN(XLEN), .PC_WIDTH(PC_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] modelQ [$];
  logic        mValid;
  logic [31:0] mCode;
  logic [31:0] mPc;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Immediates assembled arithmetically from the instruction word, one format at a time.
  function automatic ref_t refDecode(input logic [31:0] c);
    ref_t r;
    logic [31:0] sgn;
    r   = '0;
    sgn = c[31] ? 32'hFFFF_FFFF : 32'h0;
    case (c[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: r.typ = 3'd2;
      7'h37, 7'h17:                      r.typ = 3'd5;
      7'h33:                             r.typ = 3'd1;
      7'h23:                             r.typ = 3'd3;
      7'h63:                             r.typ = 3'd4;
      7'h6F:                             r.typ = 3'd6;
      default:                           r.ill = 1'b1;
    endcase
    case (r.typ)
      3'd2: r.imm = (sgn << 12) | (c >> 20);
      3'd3: r.imm = (sgn << 12) | ((c >> 25) << 5) | ((c >> 7) & 32'd31);
      3'd4: r.imm = (sgn << 12) | (((c >> 7) & 32'd1) << 11) | (((c >> 25) & 32'd63) << 5)
                    | (((c >> 8) & 32'd15) << 1);
      3'd5: r.imm = c & 32'hFFFF_F000;
      3'd6: r.imm = (sgn << 20) | (c & 32'h000F_F000) | (((c >> 20) & 32'd1) << 11)
                    | (((c >> 21) & 32'd1023) << 1);
      default: r.imm = 32'h0;
    endcase
    if (r.typ inside {3'd1, 3'd2, 3'd3, 3'd4}) r.rs1 = c[19:15];
    if (r.typ inside {3'd1, 3'd3, 3'd4})       r.rs2 = c[24:20];
    if (r.typ inside {3'd1, 3'd2, 3'd5, 3'd6}) begin
      r.rd = c[11:7];
      r.wb = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] randCode();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) == 0) return w;
    if ($urandom_range(0, 10) == 0) w[6:0] = 7'h6F;
    else w[6:0] = OPS[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    mValid = 1'b0;
    mCode  = '0;
    mPc    = '0;
  endtask

  task automatic checkModel();
    ref_t e;
    checkOutput("in_ready",   bus.in_ready,  modelQ.size() < FIFO_DEPTH);
    checkOutput("fifo_count", fifo_count,    modelQ.size());
    checkOutput("out_valid",  bus.out_valid, mValid);
    if (mValid) begin
      e = refDecode(mCode);
      checkOutput("out_pc",      bus.out_pc,      mPc);
      checkOutput("out_opcode",  bus.out_opcode,  mCode[6:0]);
      checkOutput("out_func3",   bus.out_func3,   mCode[14:12]);
      checkOutput("out_func7",   bus.out_func7,   mCode[31:25]);
      checkOutput("out_rs1",     bus.out_rs1_num, e.rs1);
      checkOutput("out_rs2",     bus.out_rs2_num, e.rs2);
      checkOutput("out_rd",      bus.out_rd_num,  e.rd);
      checkOutput("out_imm",     bus.out_imm,     e.imm);
      checkOutput("out_type",    bus.out_type,    e.typ);
      checkOutput("out_wb_reg",  bus.out_wb_reg,  e.wb);
      checkOutput("out_illegal", bus.out_illegal, e.ill);
    end
  endtask

  // Called at a falling edge: drive, advance the model across the next rising edge, check.
  task automatic applyStimulus(input logic v, input logic [31:0] c, input logic [31:0] p,
                               input logic rdy, input logic f);
    logic doPush, doPop;
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.in_pc     = p;
    bus.out_ready = rdy;
    flush         = f;
    doPush = v && (modelQ.size() < FIFO_DEPTH);
    doPop  = (modelQ.size() > 0) && (!mValid || rdy);
    if (f) begin
      modelQ.delete();
      mValid = 1'b0;
    end else begin
      if (doPop) begin
        {mCode, mPc} = modelQ.pop_front();
        mValid = 1'b1;
      end else if (mValid && rdy) begin
        mValid = 1'b0;
      end
      if (doPush) modelQ.push_back({c, p});
    end
    @(posedge clk);
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid",  bus.out_valid, 1'b0);
    checkOutput("rst_fifo_count", fifo_count,    0);
    checkOutput("rst_out_imm",    bus.out_imm,   0);
    checkOutput("rst_out_pc",     bus.out_pc,    0);
    checkOutput("rst_out_type",   bus.out_type,  0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkModel();

    $display("[TB] addi decode and latency");
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    checkOutput("lat_no_bypass", bus.out_valid, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("addi_valid", bus.out_valid,   1'b1);
    checkOutput("addi_type",  bus.out_type,    3'd2);
    checkOutput("addi_rd",    bus.out_rd_num,  5'd1);
    checkOutput("addi_rs1",   bus.out_rs1_num, 5'd0);
    checkOutput("addi_rs2",   bus.out_rs2_num, 5'd0);
    checkOutput("addi_imm",   bus.out_imm,     32'd5);
    checkOutput("addi_wb",    bus.out_wb_reg,  1'b1);
    checkOutput("addi_ill",   bus.out_illegal, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] back-pressure fill and ordered drain");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randCode(), 32'h200 + 4 * i, 1'b0, 1'b0);
    checkOutput("full_count",    fifo_count,   4);
    checkOutput("full_in_ready", bus.in_ready, 1'b0);
    checkOutput("full_head_pc",  bus.out_pc,   32'h200);
    applyStimulus(1'b1, randCode(), 32'h214, 1'b0, 1'b0);
    checkOutput("refused_count", fifo_count, 4);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_pc1", bus.out_pc, 32'h204);
    repeat (5) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] branch, jump and illegal words");
    applyStimulus(1'b1, 32'hFE00_0EE3, 32'h300, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h8000_00EF, 32'h304, 1'b1, 1'b0);
    checkOutput("beq_type", bus.out_type,   3'd4);
    checkOutput("beq_imm",  bus.out_imm,    32'hFFFF_FFFC);
    checkOutput("beq_rd",   bus.out_rd_num, 5'd0);
    checkOutput("beq_wb",   bus.out_wb_reg, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h308, 1'b1, 1'b0);
    checkOutput("jal_type", bus.out_type, 3'd6);
    checkOutput("jal_imm",  bus.out_imm,  32'hFFF0_0000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("ill_flag", bus.out_illegal, 1'b1);
    checkOutput("ill_type", bus.out_type,    3'd0);
    checkOutput("ill_imm",  bus.out_imm,     32'd0);
    checkOutput("ill_wb",   bus.out_wb_reg,  1'b0);
    checkOutput("ill_regs", {bus.out_rd_num, bus.out_rs1_num, bus.out_rs2_num}, 15'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] flush while full");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randCode(), 32'h400 + 4 * i, 1'b0, 1'b0);
    checkOutput("pre_flush_count", fifo_count, 4);
    applyStimulus(1'b1, 32'h0010_0113, 32'h4FC, 1'b0, 1'b1);
    checkOutput("flush_count", fifo_count,    0);
    checkOutput("flush_valid", bus.out_valid, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_dropped", bus.out_valid, 1'b0);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randCode(), 32'h500 + 4 * i, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", bus.out_valid, 1'b0);
    checkOutput("arst_count", fifo_count,    0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h0050_0093, 32'h600, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("arst_imm", bus.out_imm,    32'd5);
    checkOutput("arst_rd",  bus.out_rd_num, 5'd1);
    checkOutput("arst_pc",  bus.out_pc,     32'h600);

    $display("[TB] random traffic");
    repeat (400) begin
      applyStimulus($urandom_range(0, 9) < 7, randCode(), $urandom(),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
